// File: rtl/updown_counter_param.sv
// Parametrised up/down counter advanced by a clock-enable tick from an internal divider.
// Supports wrap or saturate arithmetic, programmable step and press-edge or auto-repeat stepping.
`timescale 1ns/1ps
module updown_counter_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TICK_DIV = 100000000,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic             btn_clear,
    input  logic             auto_rpt,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf
);

    localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] divider;
    logic             up_prev;
    logic             down_prev;
    logic             up_q;
    logic             down_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] count_next;
    logic             ovf_next;

    assign tick   = (divider == DIV_LAST);
    assign at_max = (count == '1);
    assign at_min = (count == '0);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            divider <= '0;
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

    // Edge mode compares against the level seen at the previous tick, not the previous cycle.
    always_comb begin
        up_q       = auto_rpt ? btn_up   : (btn_up   & ~up_prev);
        down_q     = auto_rpt ? btn_down : (btn_down & ~down_prev);
        sum        = {1'b0, count} + {1'b0, step};
        diff       = count - step;
        borrow     = (step > count);
        count_next = count;
        ovf_next   = 1'b0;
        if (btn_clear) begin
            count_next = '0;
        end else if (btn_load) begin
            count_next = load_val;
        end else if (up_q && !down_q) begin
            count_next = sum[WIDTH-1:0];
            if (sum[WIDTH]) begin
                ovf_next = 1'b1;
                if (SATURATE) begin
                    count_next = '1;
                end
            end
        end else if (down_q && !up_q) begin
            count_next = diff;
            if (borrow) begin
                ovf_next = 1'b1;
                if (SATURATE) begin
                    count_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            ovf       <= 1'b0;
            up_prev   <= 1'b0;
            down_prev <= 1'b0;
        end else begin
            ovf <= tick & ovf_next;
            if (tick) begin
                count     <= count_next;
                up_prev   <= btn_up;
                down_prev <= btn_down;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: wrap and saturate 8-bit instances share stimulus; a 4-bit
// every-cycle instance covers the full wrap sequence.
`timescale 1ns/1ps
module tb_updown_counter_param;

    typedef struct packed {
        logic [7:0] cnt;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0, btn_clear = 1'b0;
    logic       auto_rpt = 1'b0;
    logic [7:0] step = '0, load_val = '0;
    logic [7:0] count_a, count_b;
    logic       tick_a, at_max_a, at_min_a, ovf_a;
    logic       tick_b, at_max_b, at_min_b, ovf_b;

    logic       btn_up_c = 1'b0;
    logic [3:0] step_c = 4'd1;
    logic [3:0] load_val_c = '0;
    logic [3:0] count_c;
    logic       tick_c, at_max_c, at_min_c, ovf_c;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en = 1'b0, mon_c_en = 1'b0;
    logic pend_ab = 1'b0, pend_c = 1'b0;
    exp_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8), .TICK_DIV(4), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .btn_clear(btn_clear), .auto_rpt(auto_rpt), .step(step), .load_val(load_val),
        .count(count_a), .tick(tick_a), .at_max(at_max_a), .at_min(at_min_a), .ovf(ovf_a));

    updown_counter_param #(.WIDTH(8), .TICK_DIV(4), .SATURATE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .btn_clear(btn_clear), .auto_rpt(auto_rpt), .step(step), .load_val(load_val),
        .count(count_b), .tick(tick_b), .at_max(at_max_b), .at_min(at_min_b), .ovf(ovf_b));

    updown_counter_param #(.WIDTH(4), .TICK_DIV(1), .SATURATE(1'b0)) dut_c (
        .clk(clk), .rst(rst), .btn_up(btn_up_c), .btn_down(1'b0), .btn_load(1'b0),
        .btn_clear(1'b0), .auto_rpt(1'b1), .step(step_c), .load_val(load_val_c),
        .count(count_c), .tick(tick_c), .at_max(at_max_c), .at_min(at_min_c), .ovf(ovf_c));

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: a tick seen before an edge means updated outputs at the following negedge.
    always @(posedge clk) begin
        pend_ab <= mon_en && tick_a && !rst;
        pend_c  <= mon_c_en && tick_c && !rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (pend_ab) begin
            if (qa.size() == 0) begin
                check("a_sb_underflow", 32'(qa.size()), 32'(1));
            end else begin
                e = qa.pop_front();
                check("a_count",  32'(count_a),  32'(e.cnt));
                check("a_ovf",    32'(ovf_a),    32'(e.ovf));
                check("a_at_max", 32'(at_max_a), 32'(e.cnt == 8'hFF));
                check("a_at_min", 32'(at_min_a), 32'(e.cnt == 8'h00));
            end
            if (qb.size() == 0) begin
                check("b_sb_underflow", 32'(qb.size()), 32'(1));
            end else begin
                e = qb.pop_front();
                check("b_count",  32'(count_b),  32'(e.cnt));
                check("b_ovf",    32'(ovf_b),    32'(e.ovf));
                check("b_at_max", 32'(at_max_b), 32'(e.cnt == 8'hFF));
                check("b_at_min", 32'(at_min_b), 32'(e.cnt == 8'h00));
            end
        end
        if (pend_c) begin
            if (qc.size() == 0) begin
                check("c_sb_underflow", 32'(qc.size()), 32'(1));
            end else begin
                e = qc.pop_front();
                check("c_count", 32'(count_c), 32'(e.cnt));
                check("c_ovf",   32'(ovf_c),   32'(e.ovf));
            end
        end
    end

    // Apply inputs for the next tick of the 8-bit pair and queue the hand-computed results.
    task automatic tick_vec(input logic clr, input logic ld, input logic up, input logic dn,
                            input logic ar, input logic [7:0] st, input logic [7:0] lv,
                            input logic [7:0] ea, input logic oa,
                            input logic [7:0] eb, input logic ob);
        btn_clear = clr; btn_load = ld; btn_up = up; btn_down = dn;
        auto_rpt = ar; step = st; load_val = lv;
        qa.push_back('{cnt: ea, ovf: oa});
        qb.push_back('{cnt: eb, ovf: ob});
        for (int n = 0; n < 16 && !tick_a; n++) @(negedge clk);
        if (!tick_a) check("tick_timeout", 32'(tick_a), 32'(1));
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_count_a", 32'(count_a),  32'(0));
        check("rst_count_b", 32'(count_b),  32'(0));
        check("rst_count_c", 32'(count_c),  32'(0));
        check("rst_ovf_a",   32'(ovf_a),    32'(0));
        check("rst_tick_a",  32'(tick_a),   32'(0));
        check("rst_at_min",  32'(at_min_a), 32'(1));
        check("rst_at_max",  32'(at_max_a), 32'(0));

        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("tick_phase_a", 32'(tick_a), 32'(k % 4 == 3));
            check("tick_phase_b", 32'(tick_b), 32'(k % 4 == 3));
        end
        rst = 1'b1;
        @(negedge clk);
        check("tick_in_rst", 32'(tick_a), 32'(0));
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("tick_restart", 32'(tick_a), 32'(k == 3));
        end
        check("idle_count", 32'(count_a), 32'(0));

        mon_en = 1'b1;
        //        clr  ld   up   dn   ar   step   lval   A      oA   B      oB
        for (int i = 0; i < 5; i++)
            tick_vec(0,   0,   1,   0,   0,   8'd1,  8'h00, 8'h01, 0,   8'h01, 0);
        tick_vec(0,   0,   0,   0,   0,   8'd1,  8'h00, 8'h01, 0,   8'h01, 0);
        tick_vec(0,   0,   1,   0,   0,   8'd1,  8'h00, 8'h02, 0,   8'h02, 0);
        tick_vec(0,   1,   0,   0,   1,   8'd1,  8'hFE, 8'hFE, 0,   8'hFE, 0);
        tick_vec(0,   0,   1,   0,   1,   8'd3,  8'hFE, 8'h01, 1,   8'hFF, 1);
        tick_vec(0,   0,   1,   0,   1,   8'd3,  8'hFE, 8'h04, 0,   8'hFF, 1);
        tick_vec(0,   0,   0,   0,   1,   8'd3,  8'hFE, 8'h04, 0,   8'hFF, 0);
        tick_vec(0,   1,   0,   0,   1,   8'd3,  8'h02, 8'h02, 0,   8'h02, 0);
        tick_vec(0,   0,   0,   1,   1,   8'd5,  8'h02, 8'hFD, 1,   8'h00, 1);
        tick_vec(0,   0,   0,   1,   1,   8'd5,  8'h02, 8'hF8, 0,   8'h00, 1);
        tick_vec(0,   0,   0,   0,   1,   8'd5,  8'h02, 8'hF8, 0,   8'h00, 0);
        tick_vec(0,   1,   0,   0,   1,   8'd5,  8'h40, 8'h40, 0,   8'h40, 0);
        tick_vec(1,   1,   1,   0,   1,   8'd5,  8'h5A, 8'h00, 0,   8'h00, 0);
        tick_vec(0,   1,   1,   0,   1,   8'd5,  8'h5A, 8'h5A, 0,   8'h5A, 0);
        tick_vec(0,   0,   1,   1,   1,   8'd5,  8'h5A, 8'h5A, 0,   8'h5A, 0);
        tick_vec(0,   0,   1,   0,   1,   8'd0,  8'h5A, 8'h5A, 0,   8'h5A, 0);
        tick_vec(0,   1,   0,   0,   1,   8'd0,  8'hFF, 8'hFF, 0,   8'hFF, 0);
        tick_vec(0,   0,   1,   0,   1,   8'd0,  8'hFF, 8'hFF, 0,   8'hFF, 0);
        tick_vec(0,   0,   1,   0,   0,   8'd1,  8'hFF, 8'hFF, 0,   8'hFF, 0);
        tick_vec(0,   0,   0,   1,   0,   8'd1,  8'hFF, 8'hFE, 0,   8'hFE, 0);
        tick_vec(0,   0,   0,   1,   0,   8'd1,  8'hFF, 8'hFE, 0,   8'hFE, 0);
        tick_vec(0,   0,   1,   0,   1,   8'd1,  8'hFF, 8'hFF, 0,   8'hFF, 0);
        tick_vec(0,   0,   1,   0,   1,   8'd1,  8'hFF, 8'h00, 1,   8'hFF, 1);
        btn_up = 1'b0;
        mon_en = 1'b0;

        for (int i = 1; i <= 17; i++) begin
            qc.push_back('{cnt: 8'(i % 16), ovf: (i == 16)});
        end
        btn_up_c = 1'b1;
        mon_c_en = 1'b1;
        repeat (17) @(negedge clk);
        btn_up_c = 1'b0;
        mon_c_en = 1'b0;

        repeat (3) @(negedge clk);
        check("qa_drained", 32'(qa.size()), 32'(0));
        check("qb_drained", 32'(qb.size()), 32'(0));
        check("qc_drained", 32'(qc.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the 8-bit board up/down counter.
- Generic WIDTH; selectable wrap or saturate arithmetic; programmable step size.
- Single-step (press-edge) or auto-repeat mode.
- Uses a clock-enable tick from an internal divider instead of a derived slow clock; the whole block runs on the single board clock and drives LEDs or downstream logic.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- TICK_DIV, 100000000, clk cycles per update tick (>=1; 1 = every cycle).
- SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp at 0 / 2^WIDTH-1.

Ports:
- clk  input  1  board clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- btn_up  input  1  count up request.
- btn_down  input  1  count down request.
- btn_load  input  1  load request.
- btn_clear  input  1  clear request.
- auto_rpt  input  1  0 = one step per press edge; 1 = one step per tick while held.
- step  input  WIDTH  increment/decrement magnitude.
- load_val  input  WIDTH  value loaded on btn_load.
- count  output  WIDTH  registered counter value.
- tick  output  1  update strobe, high one cycle every TICK_DIV cycles.
- at_max  output  1  count == all ones.
- at_min  output  1  count == 0.
- ovf  output  1  one-cycle pulse: last step wrapped or was clamped.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Sampled only on posedge clk; it overrides all other inputs.
- Reset values: count=0, divider=0, ovf=0, button history regs=0. Combinationally, tick=0, at_min=1 and at_max=0.
- Divider:
  - Counts 0..TICK_DIV-1, then returns to 0.
  - tick = (divider == TICK_DIV-1), combinational from the divider register.
  - After rst deasserts, the first tick is high in the TICK_DIV-th cycle (divider value TICK_DIV-1).
  - Reset mid-period restarts the period.
- All counter actions evaluate only in cycles where tick=1. Results are visible on count the following cycle. Between ticks count holds, and button changes are ignored.
- Priority at a tick: btn_clear > btn_load > up/down.
  - clear: count <= 0.
  - load: count <= load_val.
- Up/down qualification:
  - auto_rpt=1: raw btn level.
  - auto_rpt=0: level high at this tick AND low at the previous tick. History regs update every tick regardless of action taken.
- Qualified up AND qualified down together → no change, ovf=0.
- Up arithmetic:
  - sum = count + step, computed at WIDTH+1 bits.
  - If carry is set: wrap mode gives count <= sum[WIDTH-1:0]; saturate mode gives count <= all ones. Either way ovf pulses.
- Down arithmetic:
  - If step > count: wrap mode gives count <= (count - step) mod 2^WIDTH; saturate mode gives count <= 0. Either way ovf pulses.
- step=0 → no change, no ovf.
- Saturate mode, already at the bound with step > 0 → count unchanged, ovf pulses (clamped).
- ovf:
  - Registered; high exactly the one cycle after the qualifying tick, coincident with the new count.
  - Clear and load never raise ovf.
- at_max and at_min are combinational from the count register.
- Changing auto_rpt between ticks takes effect at the next tick. The edge history is unaffected.

Test Plan (WIDTH=8, TICK_DIV=4 unless stated):
- Reset then idle: tick pulses in cycles 3, 7, 11…; count=0, at_min=1. Assert rst at cycle 5 → next tick 4 cycles after deassert.
- auto_rpt=0, step=1, btn_up held 5 ticks → count=1 only; release 1 tick, press again → 2.
- auto_rpt=1, SATURATE=0, count loaded to 8'hFE, step=3, btn_up held 1 tick → count=8'h01, ovf high 1 cycle. Repeat with SATURATE=1 → count=8'hFF, at_max=1, ovf pulses; next tick → count stays 8'hFF, ovf pulses again.
- auto_rpt=1, count=2, step=5, btn_down for 1 tick → wrap mode count=8'hFD, ovf=1; saturate mode count=0, at_min=1, ovf=1.
- Priority: btn_clear+btn_load+btn_up all high at a tick with count=8'h40 → count=0, ovf=0. Then btn_load+btn_up with load_val=8'h5A → 8'h5A. Then btn_up+btn_down (auto_rpt=1) → 8'h5A unchanged.
- TICK_DIV=1, WIDTH=4, auto_rpt=1, step=1, btn_up held 17 cycles from 0 → count sequence 1..15,0,1; ovf high exactly once (cycle after the 15→0 step).
